// File: rtl/shift_div_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_div_if
// Brief    : Execute-stage <-> divider handshake bundle. The execute stage
//            is the master (issues operations, consumes results); the
//            divider is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_div_if #(
  parameter int WIDTH = 64
);
  logic             i_flush;
  logic             i_start;
  logic             i_divw;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_end_valid;
  logic             i_end_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  modport master (
    output i_flush, i_start, i_divw, i_signed, i_dividend, i_divisor, i_end_ready,
    input  o_busy, o_end_valid, o_quotient, o_remainder
  );

  modport slave (
    input  i_flush, i_start, i_divw, i_signed, i_dividend, i_divisor, i_end_ready,
    output o_busy, o_end_valid, o_quotient, o_remainder
  );
endinterface
`default_nettype wire

// File: rtl/shift_div.sv
`default_nettype none
// ============================================================================
// Module   : shift_div
// Brief    : Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
//            and their W variants. Divide-by-zero and signed overflow are
//            resolved in one cycle; everything else takes one step per bit.
// Revision : 1.0 - initial release
// ============================================================================
module shift_div #(
  parameter int WIDTH = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  shift_div_if.slave  bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  // Most negative value, full width and 32-bit-sign-extended.
  localparam logic [WIDTH-1:0] c_MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_MIN_W = {{(WIDTH-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH:0]       r_rem;    // partial remainder, one guard bit
  logic [WIDTH-1:0]     r_dvd;    // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0]     r_dvs;    // divisor magnitude
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_qneg;
  logic                 r_rneg;
  logic                 r_divw;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_remo;

  // W results are always the low word sign-extended, even for DIVUW/REMUW.
  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
    return {{(WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  // ---------------------------------------------------------------- operands
  logic [WIDTH-1:0] w_a_ext;
  logic [WIDTH-1:0] w_b_ext;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div0;
  logic             w_ovf;

  // Extend W operands, take magnitudes and spot the single-cycle corner cases.
  always_comb begin
    if (bus.i_divw) begin
      w_a_ext = {{(WIDTH-32){bus.i_signed & bus.i_dividend[31]}}, bus.i_dividend[31:0]};
      w_b_ext = {{(WIDTH-32){bus.i_signed & bus.i_divisor[31]}},  bus.i_divisor[31:0]};
    end else begin
      w_a_ext = bus.i_dividend;
      w_b_ext = bus.i_divisor;
    end
    w_sa    = bus.i_signed & w_a_ext[WIDTH-1];
    w_sb    = bus.i_signed & w_b_ext[WIDTH-1];
    w_a_abs = w_sa ? (~w_a_ext + 1'b1) : w_a_ext;
    w_b_abs = w_sb ? (~w_b_ext + 1'b1) : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = bus.i_signed && (w_b_ext == {WIDTH{1'b1}}) &&
              (w_a_ext == (bus.i_divw ? c_MIN_W : c_MIN_D));
  end

  // ------------------------------------------------------------ one step
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sub;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_qmag;
  logic [WIDTH-1:0] w_rmag;
  logic [WIDTH-1:0] w_qsgn;
  logic [WIDTH-1:0] w_rsgn;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  // Restoring step plus sign fix-up of the result produced by the final step.
  always_comb begin
    w_shift   = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    w_sub     = {1'b0, w_shift} - {2'b00, r_dvs};
    w_borrow  = w_sub[WIDTH+1];
    w_rem_nxt = w_borrow ? w_shift : w_sub[WIDTH:0];
    w_dvd_nxt = {r_dvd[WIDTH-2:0], ~w_borrow};
    w_last    = (r_cnt == c_CNT_W'(1));
    w_qmag    = r_divw ? {{(WIDTH-32){1'b0}}, w_dvd_nxt[31:0]} : w_dvd_nxt;
    w_rmag    = w_rem_nxt[WIDTH-1:0];
    w_qsgn    = r_qneg ? (~w_qmag + 1'b1) : w_qmag;
    w_rsgn    = r_rneg ? (~w_rmag + 1'b1) : w_rmag;
    w_q_fin   = r_divw ? sext32(w_qsgn) : w_qsgn;
    w_r_fin   = r_divw ? sext32(w_rsgn) : w_rsgn;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: flush wins over everything but reset.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_start) w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_CALC;
        S_CALC: if (w_last)      w_state_nxt = S_DONE;
        S_DONE: if (bus.i_end_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_divw <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
    end else if (!bus.i_flush) begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_rem  <= '0;
            // W dividends are left-aligned so the MSB shifts out first.
            r_dvd  <= bus.i_divw ? {w_a_abs[31:0], {(WIDTH-32){1'b0}}} : w_a_abs;
            r_dvs  <= w_b_abs;
            r_cnt  <= bus.i_divw ? c_CNT_W'(32) : c_CNT_W'(WIDTH);
            r_qneg <= w_sa ^ w_sb;
            r_rneg <= w_sa;
            r_divw <= bus.i_divw;
            if (w_div0) begin
              r_quot <= {WIDTH{1'b1}};
              r_remo <= bus.i_divw ? sext32(w_a_ext) : w_a_ext;
            end else if (w_ovf) begin
              r_quot <= w_a_ext;
              r_remo <= '0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_quot <= w_q_fin;
            r_remo <= w_r_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_end_valid = (r_state == S_DONE);
  assign bus.o_quotient  = r_quot;
  assign bus.o_remainder = r_remo;

endmodule
`default_nettype wire

// File: tb/tb_shift_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_div
// Brief    : Directed self-checking bench for shift_div.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_div_if #(.WIDTH(64)) bus ();

  shift_div #(.WIDTH(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
    bus.i_divw     = w;
    bus.i_signed   = s;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
  endtask

  // Issue an op, wait for valid and check latency, busy and results.
  task automatic run_op(input string tag, input logic w, input logic s,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] eq, input logic [63:0] er);
    int   cyc;
    logic busy_ok;
    start_op(w, s, a, b);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.o_end_valid && cyc < 200) begin
      if (!bus.o_busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    if (!bus.o_busy) busy_ok = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " q"}, bus.o_quotient, eq);
    check({tag, " r"}, bus.o_remainder, er);
  endtask

  task automatic handshake(input string tag);
    bus.i_end_ready = 1'b1;
    tick();
    bus.i_end_ready = 1'b0;
    check({tag, " idle busy"}, {63'd0, bus.o_busy}, 64'd0);
    check({tag, " idle valid"}, {63'd0, bus.o_end_valid}, 64'd0);
  endtask

  initial begin
    int seen;
    bus.i_flush     = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_divw      = 1'b0;
    bus.i_signed    = 1'b0;
    bus.i_dividend  = '0;
    bus.i_divisor   = '0;
    bus.i_end_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy",  {63'd0, bus.o_busy}, 64'd0);
    check("reset valid", {63'd0, bus.o_end_valid}, 64'd0);
    check("reset q", bus.o_quotient, 64'd0);
    check("reset r", bus.o_remainder, 64'd0);

    run_op("divu 100/7", 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2);
    handshake("divu 100/7");
    run_op("div -7/2", 1'b0, 1'b1, -64'sd7, 64'd2, 65, -64'sd3, -64'sd1);
    handshake("div -7/2");
    run_op("div 7/-2", 1'b0, 1'b1, 64'd7, -64'sd2, 65, -64'sd3, 64'd1);
    handshake("div 7/-2");
    run_op("divuw", 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0010, 64'd3, 33, 64'd5, 64'd1);
    handshake("divuw");
    run_op("divw -7/2", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 33,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake("divw -7/2");
    run_op("divw ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
           64'hFFFF_FFFF_8000_0000, 64'd0);
    handshake("divw ovf");
    run_op("divu by0", 1'b0, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    handshake("divu by0");
    run_op("div ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
           64'h8000_0000_0000_0000, 64'd0);
    handshake("div ovf");

    // Backpressure: hold in DONE, pulse a divide-by-zero start that must be ignored.
    run_op("bp", 1'b0, 1'b0, 64'd20, 64'd4, 65, 64'd5, 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.i_dividend = 64'd99;
        bus.i_divisor  = 64'd0;
        bus.i_start    = 1'b1;
      end
      tick();
      bus.i_start = 1'b0;
      check("bp valid held", {63'd0, bus.o_end_valid}, 64'd1);
      check("bp busy held",  {63'd0, bus.o_busy}, 64'd1);
      check("bp q stable", bus.o_quotient, 64'd5);
      check("bp r stable", bus.o_remainder, 64'd0);
    end
    handshake("bp");

    // Flush at CALC step 10.
    start_op(1'b0, 1'b0, 64'd1000, 64'd7);
    for (int i = 1; i < 10; i++) tick();
    check("flush busy before", {63'd0, bus.o_busy}, 64'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("flush busy", {63'd0, bus.o_busy}, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.o_end_valid) seen++;
      tick();
    end
    check("flush valid never", 64'(seen), 64'd0);
    check("flush q kept", bus.o_quotient, 64'd5);
    run_op("after flush 9/3", 1'b0, 1'b0, 64'd9, 64'd3, 65, 64'd3, 64'd0);
    handshake("after flush");

    // Reset at CALC step 10.
    start_op(1'b0, 1'b0, 64'd1000, 64'd7);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy",  {63'd0, bus.o_busy}, 64'd0);
    check("midrst valid", {63'd0, bus.o_end_valid}, 64'd0);
    check("midrst q", bus.o_quotient, 64'd0);
    check("midrst r", bus.o_remainder, 64'd0);
    run_op("after rst 9/3", 1'b0, 1'b0, 64'd9, 64'd3, 65, 64'd3, 64'd0);
    handshake("after rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
